// File: rtl/udp_status_sender_pkg.sv
// Shared types and constants for the UDP status reply sender.
package udp_status_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int unsigned NUM_WORDS = 5;

  // Payload word positions inside the reply.
  localparam logic [2:0] WORD_MAGIC = 3'd0;
  localparam logic [2:0] WORD_SEQ   = 3'd1;
  localparam logic [2:0] WORD_FRAME = 3'd2;
  localparam logic [2:0] WORD_RXPKT = 3'd3;
  localparam logic [2:0] WORD_DROP  = 3'(NUM_WORDS - 1);

  // UDP payload length in bytes: five 32-bit words.
  localparam logic [15:0] REPLY_LENGTH = 16'(NUM_WORDS * 4);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/udp_status_sender_if.sv
// Stream bundle toward the LiteEth UDP sink port.
interface udp_status_sender_if;
  logic        valid;
  logic        last;
  logic        ready;
  logic [15:0] src_port;
  logic [15:0] dst_port;
  logic [31:0] ip_address;
  logic [15:0] length;
  logic [31:0] data;
  logic [3:0]  error;

  modport master (
    output valid, last, src_port, dst_port, ip_address, length, data, error,
    input  ready
  );

  modport slave (
    input  valid, last, src_port, dst_port, ip_address, length, data, error,
    output ready
  );
endinterface

// File: rtl/udp_status_sender.sv
// Builds a fixed five-word UDP status reply for the requesting host and
// streams it into the LiteEth UDP sink. One request may wait in a pending
// slot while a reply is in flight; further requests are counted as drops.
module udp_status_sender
  import udp_status_pkg::*;
#(
  parameter logic [15:0] SRC_PORT = 16'd26177,
  parameter logic [31:0] MAGIC    = 32'h4C43_5354
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [31:0] req_ip,
  input  logic [15:0] req_port,
  input  logic [31:0] frame_count,
  input  logic [31:0] rx_pkt_count,
  output logic [15:0] drop_count,
  udp_status_sender_if.master udp_sink
);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic [31:0] data_q, data_d;
  logic [31:0] ip_q, ip_d;
  logic [15:0] port_q, port_d;
  logic [31:0] frame_q, frame_d;
  logic [31:0] rx_q, rx_d;
  logic [15:0] drop_snap_q, drop_snap_d;
  logic [31:0] seq_q, seq_d;
  logic [15:0] drop_q, drop_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_ip_q, pend_ip_d;
  logic [15:0] pend_port_q, pend_port_d;

  logic        take_pend_s;
  logic        take_live_s;
  logic        store_s;

  // Payload word for a given beat index, built from the snapshot registers.
  function automatic logic [31:0] word_at(input logic [2:0]  idx,
                                          input logic [31:0] seq,
                                          input logic [31:0] fr,
                                          input logic [31:0] rx,
                                          input logic [15:0] drp);
    case (idx)
      WORD_MAGIC: word_at = MAGIC;
      WORD_SEQ:   word_at = seq;
      WORD_FRAME: word_at = fr;
      WORD_RXPKT: word_at = rx;
      WORD_DROP:  word_at = {16'h0000, drp};
      default:    word_at = 32'h0000_0000;
    endcase
  endfunction

  // Next-state logic: packet sequencing plus pending-slot bookkeeping.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    last_d      = last_q;
    data_d      = data_q;
    ip_d        = ip_q;
    port_d      = port_q;
    frame_d     = frame_q;
    rx_d        = rx_q;
    drop_snap_d = drop_snap_q;
    seq_d       = seq_q;
    drop_d      = drop_q;
    pend_v_d    = pend_v_q;
    pend_ip_d   = pend_ip_q;
    pend_port_d = pend_port_q;

    // The pending request always has priority over a live one in IDLE.
    take_pend_s = (state_q == ST_IDLE) && pend_v_q;
    take_live_s = (state_q == ST_IDLE) && !pend_v_q && req_valid;
    store_s     = req_valid && !take_live_s;

    case (state_q)
      ST_IDLE: begin
        if (take_pend_s || take_live_s) begin
          ip_d        = take_pend_s ? pend_ip_q : req_ip;
          port_d      = take_pend_s ? pend_port_q : req_port;
          frame_d     = frame_count;
          rx_d        = rx_pkt_count;
          drop_snap_d = drop_q;
          idx_d       = WORD_MAGIC;
          valid_d     = 1'b1;
          last_d      = 1'b0;
          data_d      = MAGIC;
          state_d     = ST_SEND;
        end else begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      ST_SEND: begin
        if (valid_q && udp_sink.ready) begin
          if (idx_q == WORD_DROP) begin
            seq_d   = seq_q + 32'd1;
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = ST_GAP;
          end else begin
            idx_d  = idx_q + 3'd1;
            data_d = word_at(idx_q + 3'd1, seq_q, frame_q, rx_q, drop_snap_q);
            last_d = ((idx_q + 3'd1) == WORD_DROP);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase

    // A slot consumed this cycle counts as free for an arriving request.
    if (store_s) begin
      if (!pend_v_q || take_pend_s) begin
        pend_v_d    = 1'b1;
        pend_ip_d   = req_ip;
        pend_port_d = req_port;
      end else begin
        drop_d = sat_inc16(drop_q);
      end
    end else if (take_pend_s) begin
      pend_v_d = 1'b0;
    end else begin
      pend_v_d = pend_v_q;
    end
  end

  // State and datapath registers; async reset aborts any packet in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      idx_q       <= 3'd0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      data_q      <= 32'h0000_0000;
      ip_q        <= 32'h0000_0000;
      port_q      <= 16'h0000;
      frame_q     <= 32'h0000_0000;
      rx_q        <= 32'h0000_0000;
      drop_snap_q <= 16'h0000;
      seq_q       <= 32'h0000_0000;
      drop_q      <= 16'h0000;
      pend_v_q    <= 1'b0;
      pend_ip_q   <= 32'h0000_0000;
      pend_port_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      data_q      <= data_d;
      ip_q        <= ip_d;
      port_q      <= port_d;
      frame_q     <= frame_d;
      rx_q        <= rx_d;
      drop_snap_q <= drop_snap_d;
      seq_q       <= seq_d;
      drop_q      <= drop_d;
      pend_v_q    <= pend_v_d;
      pend_ip_q   <= pend_ip_d;
      pend_port_q <= pend_port_d;
    end
  end

  assign udp_sink.valid      = valid_q;
  assign udp_sink.last       = last_q;
  assign udp_sink.data       = data_q;
  assign udp_sink.ip_address = ip_q;
  assign udp_sink.dst_port   = port_q;
  assign udp_sink.src_port   = SRC_PORT;
  assign udp_sink.length     = REPLY_LENGTH;
  assign udp_sink.error      = 4'b0000;
  assign drop_count          = drop_q;

endmodule

// File: tb/tb_udp_status_sender.sv
// Bench for udp_status_sender: fixed vector table, directed corner cases and
// a randomized run compared against a packet-level reference model.
module tb_udp_status_sender;

  localparam logic [31:0] M     = 32'h4C43_5354;
  localparam logic [31:0] G_IP  = 32'hFFFF_FFFF;
  localparam logic [15:0] G_PT  = 16'hFFFF;
  localparam logic [31:0] G_CNT = 32'hDEAD_BEEF;

  logic        clock;
  logic        resetn;
  logic        req_valid;
  logic [31:0] req_ip;
  logic [15:0] req_port;
  logic [31:0] frame_count;
  logic [31:0] rx_pkt_count;
  logic [15:0] drop_count;

  udp_status_sender_if sink();

  udp_status_sender dut (
    .clock        (clock),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ip       (req_ip),
    .req_port     (req_port),
    .frame_count  (frame_count),
    .rx_pkt_count (rx_pkt_count),
    .drop_count   (drop_count),
    .udp_sink     (sink)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model (packet level) ----------------
  logic        m_busy, m_gap, m_pv;
  int          m_beat;
  logic [31:0] m_words [0:4];
  logic [31:0] m_seq, m_hip, m_pip;
  logic [15:0] m_hport, m_pport, m_drops;

  task automatic model_reset();
    m_busy = 1'b0; m_gap = 1'b0; m_pv = 1'b0; m_beat = 0;
    m_seq = 32'h0; m_hip = 32'h0; m_pip = 32'h0;
    m_hport = 16'h0; m_pport = 16'h0; m_drops = 16'h0;
    for (int i = 0; i < 5; i++) m_words[i] = 32'h0;
  endtask

  // Advance the model by one clock given the inputs presented to that edge.
  task automatic model_step(input logic rq, input logic [31:0] ip, input logic [15:0] pt,
                            input logic [31:0] fr, input logic [31:0] rx, input logic rdy);
    logic took_pend, took_live;
    took_pend = 1'b0;
    took_live = 1'b0;
    if (m_busy) begin
      if (rdy) begin
        if (m_beat == 4) begin
          m_busy = 1'b0;
          m_gap  = 1'b1;
          m_seq  = m_seq + 32'd1;
        end else begin
          m_beat++;
        end
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_pv || rq) begin
      took_pend  = m_pv;
      took_live  = !m_pv;
      m_hip      = m_pv ? m_pip : ip;
      m_hport    = m_pv ? m_pport : pt;
      m_words[0] = M;
      m_words[1] = m_seq;
      m_words[2] = fr;
      m_words[3] = rx;
      m_words[4] = {16'h0, m_drops};
      m_beat     = 0;
      m_busy     = 1'b1;
    end
    if (rq && !took_live) begin
      if (!m_pv || took_pend) begin
        m_pv = 1'b1; m_pip = ip; m_pport = pt;
      end else if (m_drops != 16'hFFFF) begin
        m_drops = m_drops + 16'd1;
      end
    end else if (took_pend) begin
      m_pv = 1'b0;
    end
  endtask

  logic [31:0] cap_d  [$];
  logic [31:0] cap_ip [$];

  // One cycle: compare against the model, record accepted beats, drive inputs.
  task automatic step(input logic rq, input logic [31:0] ip, input logic [15:0] pt, input logic rdy);
    @(negedge clock);
    chk("valid", 32'(sink.valid), 32'(m_busy));
    if (m_busy) begin
      chk("data", sink.data, m_words[m_beat]);
      chk("last", 32'(sink.last), 32'(m_beat == 4));
      chk("ip", sink.ip_address, m_hip);
      chk("dst_port", 32'(sink.dst_port), 32'(m_hport));
    end
    chk("drop_count", 32'(drop_count), 32'(m_drops));
    if (sink.valid && rdy) begin
      cap_d.push_back(sink.data);
      cap_ip.push_back(sink.ip_address);
    end
    req_valid    = rq;
    req_ip       = ip;
    req_port     = pt;
    frame_count  = $urandom();
    rx_pkt_count = $urandom();
    sink.ready   = rdy;
    model_step(rq, ip, pt, frame_count, rx_pkt_count, rdy);
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn    = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    model_reset();
    cap_d.delete();
    cap_ip.delete();
  endtask

  // ---------------- fixed vector table ----------------
  typedef struct {
    logic        rq;
    logic        rdy;
    logic [31:0] ip;
    logic [15:0] pt;
    logic [31:0] fr;
    logic [31:0] rx;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic [31:0] eip;
    logic [15:0] ept;
  } vec_t;

  function automatic vec_t mk(logic rq, logic rdy, logic [31:0] ip, logic [15:0] pt,
                              logic [31:0] fr, logic [31:0] rx, logic ev, logic [31:0] ed,
                              logic el, logic [31:0] eip, logic [15:0] ept);
    vec_t v;
    v.rq = rq; v.rdy = rdy; v.ip = ip; v.pt = pt; v.fr = fr; v.rx = rx;
    v.ev = ev; v.ed = ed; v.el = el; v.eip = eip; v.ept = ept;
    return v;
  endfunction

  vec_t tv [17];

  initial begin
    logic [31:0] ip1, ip2;
    ip1 = 32'h0A00_0001;
    ip2 = 32'h0A00_0002;
    // Outputs checked first at each row, then the row's inputs are driven.
    tv[0]  = mk(1'b1, 1'b1, ip1,  16'd1234, 32'd7, 32'd3, 1'b0, 32'h0,  1'b0, 32'h0, 16'h0);
    tv[1]  = mk(1'b0, 1'b1, G_IP, G_PT, G_CNT, G_CNT, 1'b1, M,      1'b0, ip1, 16'd1234);
    tv[2]  = mk(1'b0, 1'b1, G_IP, G_PT, G_CNT, G_CNT, 1'b1, 32'd0,  1'b0, ip1, 16'd1234);
    tv[3]  = mk(1'b0, 1'b1, G_IP, G_PT, G_CNT, G_CNT, 1'b1, 32'd7,  1'b0, ip1, 16'd1234);
    tv[4]  = mk(1'b0, 1'b1, G_IP, G_PT, G_CNT, G_CNT, 1'b1, 32'd3,  1'b0, ip1, 16'd1234);
    tv[5]  = mk(1'b0, 1'b1, G_IP, G_PT, G_CNT, G_CNT, 1'b1, 32'd0,  1'b1, ip1, 16'd1234);
    tv[6]  = mk(1'b0, 1'b1, G_IP, G_PT, G_CNT, G_CNT, 1'b0, 32'h0,  1'b0, 32'h0, 16'h0);
    tv[7]  = mk(1'b1, 1'b1, ip2,  16'd4321, 32'd8, 32'd5, 1'b0, 32'h0,  1'b0, 32'h0, 16'h0);
    tv[8]  = mk(1'b0, 1'b1, G_IP, G_PT, G_CNT, G_CNT, 1'b1, M,      1'b0, ip2, 16'd4321);
    tv[9]  = mk(1'b0, 1'b1, G_IP, G_PT, G_CNT, G_CNT, 1'b1, 32'd1,  1'b0, ip2, 16'd4321);
    tv[10] = mk(1'b0, 1'b0, G_IP, G_PT, G_CNT, G_CNT, 1'b1, 32'd8,  1'b0, ip2, 16'd4321);
    tv[11] = mk(1'b0, 1'b0, G_IP, G_PT, G_CNT, G_CNT, 1'b1, 32'd8,  1'b0, ip2, 16'd4321);
    tv[12] = mk(1'b0, 1'b0, G_IP, G_PT, G_CNT, G_CNT, 1'b1, 32'd8,  1'b0, ip2, 16'd4321);
    tv[13] = mk(1'b0, 1'b1, G_IP, G_PT, G_CNT, G_CNT, 1'b1, 32'd8,  1'b0, ip2, 16'd4321);
    tv[14] = mk(1'b0, 1'b1, G_IP, G_PT, G_CNT, G_CNT, 1'b1, 32'd5,  1'b0, ip2, 16'd4321);
    tv[15] = mk(1'b0, 1'b1, G_IP, G_PT, G_CNT, G_CNT, 1'b1, 32'd0,  1'b1, ip2, 16'd4321);
    tv[16] = mk(1'b0, 1'b1, G_IP, G_PT, G_CNT, G_CNT, 1'b0, 32'h0,  1'b0, 32'h0, 16'h0);
  end

  // ---------------- main sequence ----------------
  initial begin
    clock        = 1'b0;
    resetn       = 1'b0;
    req_valid    = 1'b0;
    req_ip       = 32'h0;
    req_port     = 16'h0;
    frame_count  = 32'h0;
    rx_pkt_count = 32'h0;
    sink.ready   = 1'b0;
    model_reset();

    // Reset values while resetn is held low.
    @(negedge clock);
    chk("rst_valid", 32'(sink.valid), 32'd0);
    chk("rst_last", 32'(sink.last), 32'd0);
    chk("rst_data", sink.data, 32'd0);
    chk("rst_ip", sink.ip_address, 32'd0);
    chk("rst_dst", 32'(sink.dst_port), 32'd0);
    chk("rst_src", 32'(sink.src_port), 32'd26177);
    chk("rst_len", 32'(sink.length), 32'd20);
    chk("rst_err", 32'(sink.error), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    // Single request and backpressure, from the fixed table.
    for (int i = 0; i < 17; i++) begin
      @(negedge clock);
      chk($sformatf("tv%0d_valid", i), 32'(sink.valid), 32'(tv[i].ev));
      if (tv[i].ev) begin
        chk($sformatf("tv%0d_data", i), sink.data, tv[i].ed);
        chk($sformatf("tv%0d_last", i), 32'(sink.last), 32'(tv[i].el));
        chk($sformatf("tv%0d_ip", i), sink.ip_address, tv[i].eip);
        chk($sformatf("tv%0d_dst", i), 32'(sink.dst_port), 32'(tv[i].ept));
        chk($sformatf("tv%0d_len", i), 32'(sink.length), 32'd20);
        chk($sformatf("tv%0d_src", i), 32'(sink.src_port), 32'd26177);
      end
      req_valid    = tv[i].rq;
      req_ip       = tv[i].ip;
      req_port     = tv[i].pt;
      frame_count  = tv[i].fr;
      rx_pkt_count = tv[i].rx;
      sink.ready   = tv[i].rdy;
    end

    // Pending and drop: three extra requests during one SEND.
    do_reset();
    step(1'b1, 32'h0A00_0010, 16'd100, 1'b1);
    step(1'b0, G_IP, G_PT, 1'b1);
    step(1'b1, 32'h0A00_0020, 16'd200, 1'b1);
    step(1'b1, 32'h0A00_0030, 16'd300, 1'b1);
    step(1'b0, G_IP, G_PT, 1'b1);
    step(1'b1, 32'h0A00_0040, 16'd400, 1'b1);
    repeat (14) step(1'b0, G_IP, G_PT, 1'b1);
    chk("pd_beats", 32'(cap_d.size()), 32'd10);
    if (cap_d.size() >= 10) begin
      chk("pd_p1_ip", cap_ip[0], 32'h0A00_0010);
      chk("pd_p1_drop", cap_d[4], 32'd0);
      chk("pd_p2_ip", cap_ip[5], 32'h0A00_0020);
      chk("pd_p2_seq", cap_d[6], 32'd1);
      chk("pd_p2_drop", cap_d[9], 32'd2);
    end
    chk("pd_drop_count", 32'(drop_count), 32'd2);

    // Sequence wrap with a back-door preload of the counter.
    do_reset();
    force dut.seq_q = 32'hFFFF_FFFF;
    m_seq = 32'hFFFF_FFFF;
    step(1'b0, G_IP, G_PT, 1'b1);
    release dut.seq_q;
    step(1'b1, 32'h0A00_0050, 16'd500, 1'b1);
    step(1'b1, 32'h0A00_0060, 16'd600, 1'b1);
    repeat (16) step(1'b0, G_IP, G_PT, 1'b1);
    chk("wrap_beats", 32'(cap_d.size()), 32'd10);
    if (cap_d.size() >= 10) begin
      chk("wrap_seq0", cap_d[1], 32'hFFFF_FFFF);
      chk("wrap_seq1", cap_d[6], 32'h0000_0000);
    end

    // Reset in the middle of a packet.
    do_reset();
    step(1'b1, 32'h0A00_0070, 16'd700, 1'b1);
    repeat (3) step(1'b0, G_IP, G_PT, 1'b1);
    @(negedge clock);
    chk("rm_pre_valid", 32'(sink.valid), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rm_valid", 32'(sink.valid), 32'd0);
    chk("rm_last", 32'(sink.last), 32'd0);
    chk("rm_data", sink.data, 32'd0);
    chk("rm_ip", sink.ip_address, 32'd0);
    chk("rm_dst", 32'(sink.dst_port), 32'd0);
    chk("rm_src", 32'(sink.src_port), 32'd26177);
    chk("rm_len", 32'(sink.length), 32'd20);
    req_valid = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    model_reset();
    cap_d.delete();
    cap_ip.delete();
    repeat (10) step(1'b0, G_IP, G_PT, 1'b1);
    chk("rm_idle_beats", 32'(cap_d.size()), 32'd0);
    step(1'b1, 32'h0A00_0080, 16'd800, 1'b1);
    repeat (7) step(1'b0, G_IP, G_PT, 1'b1);
    chk("rm_new_beats", 32'(cap_d.size()), 32'd5);
    if (cap_d.size() >= 5) begin
      chk("rm_new_seq", cap_d[1], 32'd0);
    end

    // Randomized traffic and backpressure against the reference model.
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      step(($urandom_range(0, 5) == 0), $urandom(), 16'($urandom()),
           ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
